// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Sequencing controller for the multicycle MIPS datapath. It fetches an
// instruction into an internal IR, then walks DECODE, EXEC, MEM and WB.
// Along the way it handshakes with the request unit and drives every
// datapath select and enable from the latched IR.
//
// Ports:
//   CLK, RST              clock (rising edge), synchronous active-high reset
//   imemload, ihit        fetched instruction word and its completion strobe
//   dhit                  data access completion strobe
//   zero                  ALU zero flag, used by BEQ/BNE in EXEC
//   iREN, dREN, dWEN      memory request lines
//   ir                    latched instruction
//   pc_wen, pc_sel        PC update strobe and next-PC source select
//   reg_wen, reg_dst      register write strobe and destination select
//   alu_src, ext_op       ALU B operand select and imm16 extension mode
//   alu_op                ALU operation code
//   wb_sel                register write-back source select
//   halt, illegal, timeout  sticky status flags
//   retired               count of completed instructions (wraps)
//   state                 current FSM state, for debug
module multicycle_control_unit #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_W        = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      imemload,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             zero,
  output logic             iREN,
  output logic             dREN,
  output logic             dWEN,
  output logic [31:0]      ir,
  output logic             pc_wen,
  output logic [1:0]       pc_sel,
  output logic             reg_wen,
  output logic [1:0]       reg_dst,
  output logic [1:0]       alu_src,
  output logic             ext_op,
  output logic [3:0]       alu_op,
  output logic [1:0]       wb_sel,
  output logic             halt,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALTED = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW    = 6'h23, OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3, ALU_AND = 4'd4, ALU_OR  = 4'd5;
  localparam logic [3:0] ALU_XOR = 4'd6, ALU_NOR = 4'd7, ALU_SLT = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  logic [2:0]       r_state;
  logic [31:0]      r_ir;
  logic             r_halt, r_illegal, r_timeout;
  logic [CNT_W-1:0] r_retired;
  logic [TO_W-1:0]  r_wait;

  logic [5:0]      w_op, w_funct;
  logic            w_legal, w_isHalt, w_isJ, w_isJal, w_isJr;
  logic            w_isBeq, w_isBne, w_isLw, w_isSw, w_ctlExec;
  logic            w_extOp;
  logic [1:0]      w_aluSrc, w_regDst, w_wbSel, w_pcSel;
  logic [3:0]      w_aluOp;
  logic [TO_W-1:0] w_waitNext;
  logic            w_waitExpire;

  assign w_op  = r_ir[31:26];
  assign w_funct = r_ir[5:0];

  // Instruction decode of the latched IR. The selects are driven in every
  // state; only the strobes below are qualified by state.
  always_comb begin
    w_legal  = 1'b1;
    w_isHalt = 1'b0;
    w_isJ    = 1'b0;
    w_isJal  = 1'b0;
    w_isJr   = 1'b0;
    w_isBeq  = 1'b0;
    w_isBne  = 1'b0;
    w_isLw   = 1'b0;
    w_isSw   = 1'b0;
    w_extOp  = 1'b0;
    w_aluSrc = 2'b00;
    w_aluOp  = ALU_ADD;
    w_regDst = 2'b00;
    w_wbSel  = 2'b00;
    case (w_op)
      OP_RTYPE: begin
        w_regDst = 2'b01;
        case (w_funct)
          6'h20, 6'h21: w_aluOp = ALU_ADD;
          6'h22, 6'h23: w_aluOp = ALU_SUB;
          6'h24:        w_aluOp = ALU_AND;
          6'h25:        w_aluOp = ALU_OR;
          6'h26:        w_aluOp = ALU_XOR;
          6'h27:        w_aluOp = ALU_NOR;
          6'h2A:        w_aluOp = ALU_SLT;
          6'h2B:        w_aluOp = ALU_SLTU;
          6'h00: begin
            w_aluOp  = ALU_SLL;
            w_aluSrc = 2'b10;
          end
          6'h02: begin
            w_aluOp  = ALU_SRL;
            w_aluSrc = 2'b10;
          end
          6'h08:        w_isJr  = 1'b1;
          default:      w_legal = 1'b0;
        endcase
      end
      OP_J:   w_isJ = 1'b1;
      OP_JAL: begin
        w_isJal  = 1'b1;
        w_regDst = 2'b10;
        w_wbSel  = 2'b10;
      end
      OP_BEQ, OP_BNE: begin
        w_isBeq = (w_op == OP_BEQ);
        w_isBne = (w_op == OP_BNE);
        w_extOp = 1'b1;
        w_aluOp = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        w_extOp  = 1'b1;
        w_aluSrc = 2'b01;
        w_aluOp  = (w_op == OP_SLTI)  ? ALU_SLT  :
                   (w_op == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        w_aluSrc = 2'b01;
        w_aluOp  = (w_op == OP_ANDI) ? ALU_AND :
                   (w_op == OP_ORI)  ? ALU_OR  : ALU_XOR;
      end
      OP_LUI: w_wbSel = 2'b11;
      OP_LW, OP_SW: begin
        w_isLw   = (w_op == OP_LW);
        w_isSw   = (w_op == OP_SW);
        w_extOp  = 1'b1;
        w_aluSrc = 2'b01;
        w_wbSel  = (w_op == OP_LW) ? 2'b01 : 2'b00;
      end
      OP_HALT: w_isHalt = 1'b1;
      default: w_legal  = 1'b0;
    endcase
  end

  assign w_ctlExec    = w_isJ | w_isJr | w_isBeq | w_isBne;
  assign w_waitNext   = r_wait + TO_W'(1);
  // The limit is reached on the cycle whose no-hit increment would land on
  // MEM_TIMEOUT; a hit in that same cycle is checked first and wins.
  assign w_waitExpire = (MEM_TIMEOUT != 0) && (w_waitNext == TO_LIMIT);

  // Next-PC source: control transfers resolve in EXEC, JAL links in WB.
  always_comb begin
    w_pcSel = 2'b00;
    if (r_state == EXEC) begin
      if (w_isJ)        w_pcSel = 2'b10;
      else if (w_isJr)  w_pcSel = 2'b11;
      else if (w_isBeq) w_pcSel = zero ? 2'b01 : 2'b00;
      else if (w_isBne) w_pcSel = zero ? 2'b00 : 2'b01;
    end else if (r_state == WB && w_isJal) begin
      w_pcSel = 2'b10;
    end
  end

  // Sequencer, IR capture, sticky flags, retire counter and memory-wait
  // counter. The wait counter is cleared whenever FETCH or MEM is entered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= FETCH;
      r_ir      <= '0;
      r_halt    <= 1'b0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
      r_retired <= '0;
      r_wait    <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (ihit) begin
            r_ir    <= imemload;
            r_state <= DECODE;
          end else if (w_waitExpire) begin
            r_timeout <= 1'b1;
            r_halt    <= 1'b1;
            r_state   <= HALTED;
          end else begin
            r_wait <= w_waitNext;
          end
        end
        DECODE: begin
          if (!w_legal) begin
            r_illegal <= 1'b1;
            r_halt    <= 1'b1;
            r_state   <= HALTED;
          end else if (w_isHalt) begin
            r_halt    <= 1'b1;
            r_retired <= r_retired + CNT_W'(1);
            r_state   <= HALTED;
          end else begin
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (w_ctlExec) begin
            r_retired <= r_retired + CNT_W'(1);
            r_wait    <= '0;
            r_state   <= FETCH;
          end else if (w_isLw || w_isSw) begin
            r_wait  <= '0;
            r_state <= MEM;
          end else begin
            r_state <= WB;
          end
        end
        MEM: begin
          if (dhit) begin
            if (w_isSw) begin
              r_retired <= r_retired + CNT_W'(1);
              r_wait    <= '0;
              r_state   <= FETCH;
            end else begin
              r_state <= WB;
            end
          end else if (w_waitExpire) begin
            r_timeout <= 1'b1;
            r_halt    <= 1'b1;
            r_state   <= HALTED;
          end else begin
            r_wait <= w_waitNext;
          end
        end
        WB: begin
          r_retired <= r_retired + CNT_W'(1);
          r_wait    <= '0;
          r_state   <= FETCH;
        end
        HALTED:  r_state <= HALTED;
        default: r_state <= FETCH;
      endcase
    end
  end

  // Strobes are combinational from state and IR. The write strobes are
  // masked by RST so a reset cycle never commits architectural state.
  assign iREN    = (r_state == FETCH);
  assign dREN    = (r_state == MEM) && w_isLw;
  assign dWEN    = (r_state == MEM) && w_isSw;
  assign reg_wen = !RST && (r_state == WB);
  assign pc_wen  = !RST && (((r_state == EXEC) && w_ctlExec) ||
                            ((r_state == MEM) && w_isSw && dhit) ||
                            (r_state == WB));
  assign pc_sel  = w_pcSel;
  assign reg_dst = w_regDst;
  assign alu_src = w_aluSrc;
  assign ext_op  = w_extOp;
  assign alu_op  = w_aluOp;
  assign wb_sel  = w_wbSel;
  assign ir      = r_ir;
  assign halt    = r_halt;
  assign illegal = r_illegal;
  assign timeout = r_timeout;
  assign retired = r_retired;
  assign state   = r_state;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Sequencing controller for the multicycle MIPS datapath. It supersedes the single-cycle combinational decoder with a state machine that fetches into an internal instruction register (IR), then sequences decode, execute, memory and writeback. It handshakes with the request unit (iREN/ihit, dREN/dWEN/dhit) and drives all datapath mux selects and enables from the latched IR. It adds illegal-opcode detection, a parametrised memory-wait timeout, and a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W).
MEM_TIMEOUT, 0, maximum wait cycles for ihit/dhit; 0 disables the timeout.
TO_W, 8, width of the wait counter; MEM_TIMEOUT must be < 2^TO_W.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  reset.
imemload  in  32  instruction word from memory; valid when ihit.
ihit  in  1  instruction fetch complete.
dhit  in  1  data access complete.
zero  in  1  ALU zero flag, valid in EXEC.
iREN  out  1  instruction read request.
dREN  out  1  data read request.
dWEN  out  1  data write request.
ir  out  32  latched instruction.
pc_wen  out  1  PC update strobe.
pc_sel  out  2  00 PC+4, 01 branch target, 10 jump target, 11 R[rs] (JR).
reg_wen  out  1  register file write strobe.
reg_dst  out  2  00 rt, 01 rd, 10 r31.
alu_src  out  2  00 R[rt], 01 extended imm16, 10 shamt.
ext_op  out  1  1 = sign-extend imm16, 0 = zero-extend.
alu_op  out  4  aluop_t from cpu_types_pkg.
wb_sel  out  2  00 ALU result, 01 dmemload, 10 PC+4 (JAL), 11 {imm16,16'b0} (LUI).
halt  out  1  sticky halt.
illegal  out  1  sticky illegal-instruction flag.
timeout  out  1  sticky memory-timeout flag.
retired  out  CNT_W  count of completed instructions.
state  out  3  current FSM state, for debug.

Behaviour:
- Clocking and reset: one clock, CLK; reset RST is synchronous and active-high.
- Reset values: state=FETCH, ir=0, halt=illegal=timeout=0, retired=0, wait counter=0.
  - Outputs are combinational from state and ir; after reset all strobes are 0 except iREN=1.
  - RST asserted in any state, including mid-MEM, returns to FETCH on the next edge. No reg_wen or pc_wen is issued in that cycle.
- States and encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5.
- FETCH:
  - iREN=1.
  - On ihit: ir<=imemload, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle, for register read. Decode the opcode/funct of ir.
  - Unknown opcode or funct: illegal<=1, halt<=1, go to HALTED. The instruction is not retired.
  - HALT (0x3F): halt<=1, retired+1, go to HALTED.
  - Otherwise go to EXEC.
- EXEC: alu_op/alu_src/ext_op are driven; ALU settles. pc_wen=1 and retired+1 for J, BEQ, BNE and JR, then go to FETCH.
  - J: pc_sel=10.
  - BEQ: pc_sel = zero ? 01 : 00.
  - BNE: pc_sel = zero ? 00 : 01.
  - JR: pc_sel=11.
  - LW/SW go to MEM; all others go to WB.
- MEM:
  - LW holds dREN=1 until dhit, then goes to WB.
  - SW holds dWEN=1 until dhit; on dhit, pc_wen=1, retired+1, go to FETCH.
  - dREN and dWEN are never both 1.
- WB: reg_wen=1, pc_wen=1, pc_sel=00, retired+1, go to FETCH.
  - JAL skips MEM and uses reg_dst=10, wb_sel=10, pc_sel=10.
- HALTED: absorbing until RST. All request and strobe outputs are 0.
- Timeout: the wait counter clears on entry to FETCH or MEM and increments each cycle without a hit.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with no hit: timeout<=1, halt<=1, go to HALTED.
  - A hit arriving in the same cycle the counter reaches the limit wins.
- Decode table (ext_op, alu_src, alu_op, reg_dst, wb_sel):
  - ADDI/ADDIU: sext, imm, ADD, rt.
  - SLTI/SLTIU: sext, imm, SLT/SLTU, rt.
  - ANDI/ORI/XORI: zext, imm, AND/OR/XOR, rt.
  - LUI: rt, wb_sel=11.
  - LW/SW: sext, imm, ADD; LW uses wb_sel=01.
  - BEQ/BNE: R[rt], SUB.
  - RTYPE: reg_dst=01, alu_src=00 except SLL/SRL use 10. Funct 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU, 00 SLL, 02 SRL, 08 JR.
- Retired counter wraps from all-ones to 0 without a flag.

Test Plan:
- ADDI, ihit held low 2 cycles after reset -> FETCH for 3 cycles, then DECODE, EXEC, WB. reg_wen=pc_wen=1 for exactly one cycle; retired=1.
- LW with dhit arriving 3 cycles into MEM -> dREN=1 for 4 cycles, WB has wb_sel=01, reg_wen=1; a following SW asserts dWEN only.
- BNE with zero=0 -> pc_sel=01, pc_wen=1 in EXEC, 3 cycles total (ihit immediate); with zero=1 -> pc_sel=00.
- HALT after 5 instructions -> halt=1 sticky, retired=6, iREN=0 forever; RST returns to FETCH with retired=0.
- Opcode 0x3E -> illegal=1, halt=1, retired unchanged; RTYPE funct 0x3F behaves the same.
- MEM_TIMEOUT=4, dhit never arrives -> timeout=halt=1 after 4 MEM cycles; RST mid-MEM with dhit pending -> FETCH, no reg_wen.
